// File: rtl/simd_alu_adder_ctrl.sv
// SIMD add/sub datapath plus a two-stage issue/collect controller that
// registers operands, captures lane-wise results with flags, and keeps sticky status.

module simd_adder_lane (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] bx;

  assign bx          = b ^ {8{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
endmodule

module simd_alu_adder_top #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
  input  logic [SIMD_DATA_WIDTH-1:0]            a,
  input  logic [SIMD_DATA_WIDTH-1:0]            b,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode,
  input  logic                                  sub,
  output logic [SIMD_DATA_WIDTH-1:0]            result
);
  localparam int NB = SIMD_DATA_WIDTH / 8;

  logic [1:0] msel;
  logic [2:0] bmask;
  logic       carry_unused;

  assign msel = 2'(mode);

  always_comb begin
    bmask = 3'b111;
    case (msel)
      2'd0:    bmask = 3'b000;
      2'd1:    bmask = 3'b001;
      2'd2:    bmask = 3'b011;
      default: bmask = 3'b111;
    endcase
  end

  // Byte-sliced ripple; the chain restarts with the subtract carry-in at each element's low byte.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    localparam logic [2:0] IDX = 3'(i % 8);
    logic cin, cout;
    if (i == 0) begin : g_first
      assign cin = sub;
    end else begin : g_rest
      assign cin = ((IDX & bmask) == 3'd0) ? sub : g_lane[i-1].cout;
    end
    simd_adder_lane u_lane (
      .a   (a[8*i +: 8]),
      .b   (b[8*i +: 8]),
      .sub (sub),
      .cin (cin),
      .sum (result[8*i +: 8]),
      .cout(cout)
    );
  end

  assign carry_unused = g_lane[NB-1].cout;
endmodule

module simd_alu_adder_ctrl #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_a,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_b,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_mode,
  input  logic                                  in_signed,
  input  logic                                  in_sub,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]            out_result,
  output logic [SIMD_DATA_WIDTH/8-1:0]          out_ovf,
  output logic [SIMD_DATA_WIDTH/8-1:0]          out_udf,
  input  logic                                  sts_clr,
  output logic                                  sts_ovf_any,
  output logic                                  sts_udf_any,
  output logic [15:0]                           sts_op_cnt
);
  localparam int DW = SIMD_DATA_WIDTH;
  localparam int MW = SIMD_ADDER_DATA_MODE_WIDTH;
  localparam int NB = DW / 8;

  logic          rdy_en;
  logic          s1_valid;
  logic [DW-1:0] s1_a, s1_b;
  logic [MW-1:0] s1_mode;
  logic          s1_signed, s1_sub;
  logic [DW-1:0] sum;
  logic [NB-1:0] ovf_nxt, udf_nxt;
  logic          s2_free, s1_adv, in_fire, out_fire;
  logic [1:0]    msel;
  logic [2:0]    bmask;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  // rdy_en keeps in_ready low through reset without a combinational path from rst_n.
  assign in_ready = rdy_en && (!s1_valid || s2_free);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= '0;
      s1_signed <= 1'b0;
      s1_sub    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_mode   <= in_mode;
        s1_signed <= in_signed;
        s1_sub    <= in_sub;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  simd_alu_adder_top #(
    .SIMD_DATA_WIDTH           (DW),
    .SIMD_ADDER_DATA_MODE_WIDTH(MW)
  ) u_adder (
    .a     (s1_a),
    .b     (s1_b),
    .mode  (s1_mode),
    .sub   (s1_sub),
    .result(sum)
  );

  assign msel = 2'(s1_mode);

  always_comb begin
    bmask = 3'b111;
    case (msel)
      2'd0:    bmask = 3'b000;
      2'd1:    bmask = 3'b001;
      2'd2:    bmask = 3'b011;
      default: bmask = 3'b111;
    endcase
  end

  // Flags need only the top bit of A, effective B and the sum: the carry into
  // that bit is recovered as a^b^r, which gives both the carry out and signed overflow.
  for (genvar i = 0; i < NB; i++) begin : g_flag
    localparam logic [2:0] IDX = 3'(i % 8);
    logic a7, b7, r7, co, v, is_top;
    assign a7     = s1_a[8*i+7];
    assign b7     = s1_b[8*i+7] ^ s1_sub;
    assign r7     = sum[8*i+7];
    assign co     = (a7 & b7) | ((a7 ^ b7) & ~r7);
    assign v      = (a7 == b7) && (r7 != a7);
    assign is_top = ((IDX & bmask) == bmask);
    assign ovf_nxt[i] = is_top & (s1_signed ? (v & ~a7) : (~s1_sub & co));
    assign udf_nxt[i] = is_top & (s1_signed ? (v & a7)  : (s1_sub & ~co));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= '0;
      out_udf    <= '0;
    end else if (s1_adv) begin
      out_valid  <= 1'b1;
      out_result <= sum;
      out_ovf    <= ovf_nxt;
      out_udf    <= udf_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sts_ovf_any <= 1'b0;
      sts_udf_any <= 1'b0;
      sts_op_cnt  <= '0;
    end else if (sts_clr) begin
      // A delivery in the clearing cycle survives the clear.
      sts_ovf_any <= out_fire && (|out_ovf);
      sts_udf_any <= out_fire && (|out_udf);
      sts_op_cnt  <= out_fire ? 16'd1 : 16'd0;
    end else if (out_fire) begin
      sts_ovf_any <= sts_ovf_any | (|out_ovf);
      sts_udf_any <= sts_udf_any | (|out_udf);
      if (sts_op_cnt != 16'hFFFF) sts_op_cnt <= sts_op_cnt + 16'd1;
    end
  end
endmodule
